// File: rtl/softmax_pkg.sv
// Shared constants and lane/vector types for the softmax pipeline.
package softmax_pkg;
  localparam int LANES            = 64;
  localparam int DATA_W           = 8;
  localparam int ID_W             = 8;
  localparam int CMP_TREE_LATENCY = 7;

  typedef logic signed [DATA_W-1:0] lane_t;
  typedef logic [LANES*DATA_W-1:0]  vec_t;
endpackage

// File: rtl/softmax_max_subtract_vec_fifo.sv
// Generic synchronous first-word-fall-through FIFO with an occupancy counter.
module vec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             aclk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (level_r == '0);
  assign full      = (level_r == LVL_W'(DEPTH));
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage array: data only, no reset needed.
  always_ff @(posedge aclk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy counter with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end
endmodule

// File: rtl/softmax_max_subtract.sv
// Aligns each vector with its compare-tree max and emits x[i]-max saturated to [-128,0].
module softmax_max_subtract
  import softmax_pkg::*;
#(
  parameter int LANES      = softmax_pkg::LANES,
  parameter int DATA_W     = softmax_pkg::DATA_W,
  parameter int ID_W       = softmax_pkg::ID_W,
  parameter int FIFO_DEPTH = CMP_TREE_LATENCY + 1
) (
  input  logic                          aclk,
  input  logic                          rst_n,
  input  logic [LANES*DATA_W-1:0]       in_data,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             cmp_max_data,
  input  logic [ID_W-1:0]               cmp_max_ID,
  input  logic                          cmp_valid,
  output logic [LANES*DATA_W-1:0]       out_data,
  output logic [DATA_W-1:0]             out_max_data,
  output logic [ID_W-1:0]               out_max_ID,
  output logic                          out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_overflow,
  output logic                          err_underflow
);
  logic [LANES*DATA_W-1:0] head_s;
  logic [LANES*DATA_W-1:0] sat_vec_s;
  logic                    full_s;
  logic                    empty_s;
  logic                    pop_ok_s;
  logic                    overflow_s;
  logic                    underflow_s;
  logic [LANES*DATA_W-1:0] out_data_r;
  logic [DATA_W-1:0]       out_max_data_r;
  logic [ID_W-1:0]         out_max_ID_r;
  logic                    out_valid_r;
  logic                    err_overflow_r;
  logic                    err_underflow_r;

  vec_fifo #(
    .WIDTH (LANES*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk  (aclk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (cmp_valid),
    .din   (in_data),
    .dout  (head_s),
    .level (fifo_level),
    .full  (full_s),
    .empty (empty_s)
  );

  assign pop_ok_s    = cmp_valid && !empty_s;
  assign underflow_s = cmp_valid && empty_s;
  // Full implies non-empty, so only a missing cmp_valid makes a full push drop.
  assign overflow_s  = in_valid && full_s && !cmp_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W:0]   lane_diff_s;
    logic [DATA_W-1:0] lane_sat_s;

    assign lane_diff_s = {head_s[i*DATA_W+DATA_W-1], head_s[i*DATA_W +: DATA_W]}
                       - {cmp_max_data[DATA_W-1], cmp_max_data};

    // Clamp the 9-bit difference: top bits 10 mean below -128, sign 0 means >= 0.
    always_comb begin
      lane_sat_s = lane_diff_s[DATA_W-1:0];
      if (lane_diff_s[DATA_W] && !lane_diff_s[DATA_W-1]) begin
        lane_sat_s = {1'b1, {(DATA_W-1){1'b0}}};
      end else if (!lane_diff_s[DATA_W]) begin
        lane_sat_s = '0;
      end else begin
        lane_sat_s = lane_diff_s[DATA_W-1:0];
      end
    end

    assign sat_vec_s[i*DATA_W +: DATA_W] = lane_sat_s;
  end

  // Result registers and sticky alignment-fault flags.
  always_ff @(posedge aclk) begin
    if (!rst_n) begin
      out_data_r      <= '0;
      out_max_data_r  <= '0;
      out_max_ID_r    <= '0;
      out_valid_r     <= 1'b0;
      err_overflow_r  <= 1'b0;
      err_underflow_r <= 1'b0;
    end else begin
      out_valid_r <= pop_ok_s;
      if (pop_ok_s) begin
        out_data_r     <= sat_vec_s;
        out_max_data_r <= cmp_max_data;
        out_max_ID_r   <= cmp_max_ID;
      end
      if (overflow_s) begin
        err_overflow_r <= 1'b1;
      end
      if (underflow_s) begin
        err_underflow_r <= 1'b1;
      end
    end
  end

  assign out_data      = out_data_r;
  assign out_max_data  = out_max_data_r;
  assign out_max_ID    = out_max_ID_r;
  assign out_valid     = out_valid_r;
  assign err_overflow  = err_overflow_r;
  assign err_underflow = err_underflow_r;
endmodule

// File: tb/tb_softmax_max_subtract.sv
// Directed, table-driven bench for softmax_max_subtract with a small compare-tree model.
module tb_softmax_max_subtract;
  import softmax_pkg::*;

  logic        aclk;
  logic        rst_n;
  vec_t        in_data;
  logic        in_valid;
  logic [7:0]  cmp_max_data;
  logic [7:0]  cmp_max_ID;
  logic        cmp_valid;
  vec_t        out_data;
  logic [7:0]  out_max_data;
  logic [7:0]  out_max_ID;
  logic        out_valid;
  logic [3:0]  fifo_level;
  logic        err_overflow;
  logic        err_underflow;

  int checks = 0;
  int errors = 0;

  softmax_max_subtract dut (
    .aclk          (aclk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .cmp_max_data  (cmp_max_data),
    .cmp_max_ID    (cmp_max_ID),
    .cmp_valid     (cmp_valid),
    .out_data      (out_data),
    .out_max_data  (out_max_data),
    .out_max_ID    (out_max_ID),
    .out_valid     (out_valid),
    .fifo_level    (fifo_level),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    vec_t       data;
    logic [7:0] max;
    logic [7:0] id;
    logic [7:0] e0;
    logic [7:0] e5;
    logic [7:0] e63;
  } vec_case_t;

  vec_case_t tbl [6];
  vec_t      b2b [20];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic iv, input vec_t d, input logic cv,
                       input logic [7:0] m, input logic [7:0] id);
    in_valid = iv; in_data = d; cmp_valid = cv; cmp_max_data = m; cmp_max_ID = id;
    @(posedge aclk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  function automatic vec_t fill(input logic [7:0] b);
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  // Software reference: saturating x - max per lane.
  function automatic vec_t ref_vec(input vec_t x, input logic [7:0] m);
    vec_t r;
    int   d;
    for (int i = 0; i < LANES; i++) begin
      d = int'(lane_t'(x[i*8 +: 8])) - int'(lane_t'(m));
      if (d < -128) d = -128;
      if (d > 0) d = 0;
      r[i*8 +: 8] = 8'(d);
    end
    return r;
  endfunction

  // Compare-tree model: signed max, lowest index on ties.
  function automatic logic [15:0] tree_max(input vec_t x);
    lane_t      best;
    logic [7:0] idx;
    best = lane_t'(x[7:0]);
    idx  = 8'd0;
    for (int i = 1; i < LANES; i++) begin
      if (lane_t'(x[i*8 +: 8]) > best) begin
        best = lane_t'(x[i*8 +: 8]);
        idx  = 8'(i);
      end
    end
    return {best, idx};
  endfunction

  initial begin
    vec_t        ramp;
    vec_t        spike;
    vec_t        exp_v;
    logic [15:0] mx;
    int          peak;
    int          pulses;

    for (int i = 0; i < LANES; i++) ramp[i*8 +: 8] = 8'(i - 32);
    spike = fill(8'h80);
    spike[5*8 +: 8] = 8'h7F;
    for (int v = 0; v < 20; v++)
      for (int i = 0; i < LANES; i++) b2b[v][i*8 +: 8] = 8'((v * 37 + i * 13) % 256);

    tbl[0] = '{ramp,         8'd31,  8'd63, 8'hC1, 8'hC6, 8'h00}; // -63, -58, 0
    tbl[1] = '{spike,        8'h7F,  8'd5,  8'h80, 8'h00, 8'h80}; // d=-255 clamps
    tbl[2] = '{fill(8'h00),  8'h00,  8'd0,  8'h00, 8'h00, 8'h00};
    tbl[3] = '{ramp,         8'hF6,  8'd63, 8'hEA, 8'hEF, 8'h00}; // max=-10: -22, -17, +41->0
    tbl[4] = '{fill(8'hFF),  8'h7F,  8'd9,  8'h80, 8'h80, 8'h80}; // d=-128 exactly
    tbl[5] = '{fill(8'h7F),  8'h80,  8'd2,  8'h00, 8'h00, 8'h00}; // d=+255 clamps to 0

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cmp_valid = 1'b0;
    cmp_max_data = 8'd0; cmp_max_ID = 8'd0;
    do_reset(2);
    check("reset out_valid", 512'(out_valid), 512'(1'b0));
    check("reset out_data", out_data, '0);
    check("reset level", 512'(fifo_level), 512'(4'd0));
    check("reset flags", 512'({err_overflow, err_underflow}), 512'(2'b00));

    // Single-vector cases: push at cycle 0, max at cycle 7, result at cycle 8.
    for (int t = 0; t < 6; t++) begin
      exp_v = ref_vec(tbl[t].data, tbl[t].max);
      cycle(1'b1, tbl[t].data, 1'b0, 8'd0, 8'd0);
      idle(6);
      check($sformatf("t%0d early valid", t), 512'(out_valid), 512'(1'b0));
      check($sformatf("t%0d level before pop", t), 512'(fifo_level), 512'(4'd1));
      cycle(1'b0, '0, 1'b1, tbl[t].max, tbl[t].id);
      check($sformatf("t%0d out_valid", t), 512'(out_valid), 512'(1'b1));
      check($sformatf("t%0d lane0", t), 512'(out_data[7:0]), 512'(tbl[t].e0));
      check($sformatf("t%0d lane5", t), 512'(out_data[47:40]), 512'(tbl[t].e5));
      check($sformatf("t%0d lane63", t), 512'(out_data[511:504]), 512'(tbl[t].e63));
      check($sformatf("t%0d vector", t), out_data, exp_v);
      check($sformatf("t%0d max", t), 512'(out_max_data), 512'(tbl[t].max));
      check($sformatf("t%0d id", t), 512'(out_max_ID), 512'(tbl[t].id));
      check($sformatf("t%0d level after", t), 512'(fifo_level), 512'(4'd0));
      idle(1);
      check($sformatf("t%0d pulse ends", t), 512'(out_valid), 512'(1'b0));
      check($sformatf("t%0d data holds", t), out_data, exp_v);
    end
    check("single flags", 512'({err_overflow, err_underflow}), 512'(2'b00));

    // 20 back-to-back vectors through the compare-tree model.
    do_reset(1);
    peak = 0; pulses = 0;
    for (int c = 0; c < 28; c++) begin
      logic       cv;
      logic [7:0] m;
      logic [7:0] id;
      cv = (c >= 7) && (c < 27);
      mx = cv ? tree_max(b2b[c-7]) : 16'd0;
      m = mx[15:8]; id = mx[7:0];
      cycle(c < 20, (c < 20) ? b2b[c] : '0, cv, m, id);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (out_valid) pulses++;
      check($sformatf("b2b c%0d valid", c), 512'(out_valid), 512'(cv));
      if (cv) begin
        check($sformatf("b2b c%0d data", c), out_data, ref_vec(b2b[c-7], m));
        check($sformatf("b2b c%0d id", c), 512'(out_max_ID), 512'(id));
      end
    end
    check("b2b pulses", 512'(pulses), 512'(20));
    check("b2b peak level", 512'(peak), 512'(7));
    check("b2b end level", 512'(fifo_level), 512'(4'd0));
    check("b2b flags", 512'({err_overflow, err_underflow}), 512'(2'b00));

    // Overflow: nine pushes, ninth dropped, then eight ordered pops.
    do_reset(1);
    for (int k = 1; k <= 8; k++) cycle(1'b1, fill(8'(k)), 1'b0, 8'd0, 8'd0);
    check("ovf before 9th", 512'(err_overflow), 512'(1'b0));
    check("ovf level 8", 512'(fifo_level), 512'(4'd8));
    cycle(1'b1, fill(8'd9), 1'b0, 8'd0, 8'd0);
    check("ovf flag", 512'(err_overflow), 512'(1'b1));
    check("ovf level held", 512'(fifo_level), 512'(4'd8));
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, '0, 1'b1, 8'h7F, 8'(k));
      check($sformatf("ovf pop%0d valid", k), 512'(out_valid), 512'(1'b1));
      check($sformatf("ovf pop%0d data", k), out_data, fill(8'(k - 127)));
      check($sformatf("ovf pop%0d id", k), 512'(out_max_ID), 512'(8'(k)));
    end
    check("ovf drained", 512'(fifo_level), 512'(4'd0));
    check("ovf no underflow", 512'(err_underflow), 512'(1'b0));

    // Underflow, then push+pop while empty.
    do_reset(1);
    cycle(1'b0, '0, 1'b1, 8'd3, 8'd4);
    check("unf out_valid", 512'(out_valid), 512'(1'b0));
    check("unf flag", 512'(err_underflow), 512'(1'b1));
    check("unf level", 512'(fifo_level), 512'(4'd0));
    cycle(1'b1, ramp, 1'b1, 8'd3, 8'd4);
    check("unf push+pop level", 512'(fifo_level), 512'(4'd1));
    check("unf push+pop valid", 512'(out_valid), 512'(1'b0));

    // Reset mid-stream with three vectors queued.
    cycle(1'b1, spike, 1'b0, 8'd0, 8'd0);
    cycle(1'b1, ramp, 1'b0, 8'd0, 8'd0);
    check("rst queued 3", 512'(fifo_level), 512'(4'd3));
    do_reset(1);
    check("rst level", 512'(fifo_level), 512'(4'd0));
    check("rst flags", 512'({err_overflow, err_underflow}), 512'(2'b00));
    check("rst out_valid", 512'(out_valid), 512'(1'b0));
    cycle(1'b0, '0, 1'b1, 8'd1, 8'd1);
    check("rst then underflow", 512'(err_underflow), 512'(1'b1));
    check("rst then no output", 512'(out_valid), 512'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/softmax_max_subtract.md
Name: softmax_max_subtract

Overview:
- Sits directly downstream of the 64-lane compare tree in the softmax pipeline.
- Holds each incoming 64×int8 vector in a FIFO while the compare tree computes that vector's max (fixed 7-cycle latency).
- When the max arrives, pops the matching vector, computes x[i] − max per lane with saturation to [−128, 0], and emits the normalised vector to the exp stage.
- The compare tree cannot be stalled, so this block has no backpressure; alignment faults are reported through sticky error flags.

Parameters:
- LANES, 64, number of int8 lanes per beat.
- DATA_W, 8, lane width in bits (signed).
- ID_W, 8, width of the max index.
- FIFO_DEPTH, 8, vector FIFO depth; must be ≥ compare-tree latency (7) + 1.

Ports:
- aclk  in  1  clock.
- rst_n  in  1  reset.
- in_data  in  LANES*DATA_W  raw vector, lane i = bits [8i+7:8i]; same beat the compare tree receives.
- in_valid  in  1  in_data valid; same pulse the compare tree receives.
- cmp_max_data  in  DATA_W  signed max from the compare tree.
- cmp_max_ID  in  ID_W  lane index of the max.
- cmp_valid  in  1  compare tree output valid.
- out_data  out  LANES*DATA_W  signed lane results x[i] − max, saturated.
- out_max_data  out  DATA_W  max forwarded with the vector.
- out_max_ID  out  ID_W  max index forwarded.
- out_valid  out  1  one-cycle pulse per result vector.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_overflow  out  1  sticky: push dropped because the FIFO was full.
- err_underflow  out  1  sticky: cmp_valid arrived with the FIFO empty.

Behaviour:
- Reset is rst_n, synchronous, active-low; clock is aclk.
- All outputs, FIFO pointers and flags reset to 0.
- Reset mid-operation discards all queued vectors.
- Push:
  - in_valid=1 writes in_data at the tail.
  - If the FIFO is full and no pop occurs in the same cycle, the write is dropped, err_overflow←1 and the level is unchanged.
- Pop:
  - cmp_valid=1 reads the head vector (first-word fall-through, available combinationally).
  - If the FIFO is empty: no output, out_valid stays 0, err_underflow←1.
- Simultaneous push and pop: both happen.
  - Level is unchanged.
  - Legal when full (the pop frees a slot).
  - When empty, the pop is an underflow and the push still occurs.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked by a counter, 0..FIFO_DEPTH.
- Arithmetic, per lane:
  - d = sext9(x[i]) − sext9(cmp_max_data), range −255..+255.
  - out lane = −128 if d < −128; 0 if d > 0; otherwise d[7:0].
  - A positive d indicates misalignment; it is clamped and not flagged.
- Latency:
  - out_* are registered.
  - out_valid rises exactly 1 cycle after the cmp_valid cycle that popped, i.e. 8 cycles after the matching in_valid.
  - out_max_data and out_max_ID are registered copies of the cmp_* inputs from that same cycle.
  - out_data, out_max_data and out_max_ID hold their last values while out_valid=0.
- Throughput:
  - One vector per cycle sustained.
  - Back-to-back in_valid keeps the level ≤ 7 in steady state.
- Flags clear only on reset.

Decomposition:
- Shared package softmax_pkg:
  - constants LANES=64, DATA_W=8, ID_W=8, CMP_TREE_LATENCY=7.
  - typedef lane_t (signed [7:0]).
  - typedef vec_t (LANES*DATA_W packed).
- Sub-module vec_fifo:
  - generic synchronous first-word-fall-through FIFO (WIDTH, DEPTH).
  - ports: push, pop, din, dout, level, full, empty.
  - reusable elsewhere in the pipeline.
- Saturating subtract: a generate loop in the top module; no sub-module.

Test Plan:
- Single vector, lanes x[i]=i−32, in_valid at cycle 0, cmp pulse at cycle 7 with max=31, ID=63 → out_valid at cycle 8; lane 0 = −63, lane 63 = 0, out_max_ID=63; fifo_level returns to 0.
- Saturation: all lanes −128 except lane 5 = 127, max=127 → lane 5 = 0, all other lanes = −128 (d=−255 clamped).
- 20 back-to-back vectors, each driven through a real compare-tree model → 20 consecutive out_valid pulses, in order, each matching the software reference; level peaks at 7; no error flags.
- Overflow: 9 pushes with no cmp_valid → 9th push dropped, err_overflow=1, fifo_level=8; then 8 pops return vectors 1..8 in order.
- Underflow: cmp_valid with the FIFO empty → out_valid stays 0, err_underflow=1.
  - Same-cycle push+pop while empty → level becomes 1.
- Reset mid-stream: 3 vectors queued, rst_n=0 for 1 cycle → level=0, flags=0, out_valid=0; a subsequent cmp_valid sets err_underflow.
